// File: rtl/block_stream_emitter.sv
// Serialises BEGIN/END/NOP/FLUSH commands as ASCII words ("begin ", "end ", "nop "), one char per clock.
// Optional build macro BLOCK_EMIT_STRICT_EN: END at depth 0 is silently discarded and underflow stays 0.
module block_stream_emitter #(
  parameter int unsigned DEPTH_W    = 16,
  parameter int unsigned UPPER_CASE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               balanced
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FLUSH_EMIT = 2'd2} state_t;
  typedef enum logic [1:0] {W_BEGIN = 2'd0, W_END = 2'd1, W_NOP = 2'd2} word_t;
  typedef enum logic [1:0] {OP_BEGIN = 2'd0, OP_END = 2'd1, OP_NOP = 2'd2, OP_FLUSH = 2'd3} op_t;

  state_t             state, state_n;
  word_t              word, word_n;
  logic [2:0]         idx, idx_n, last_idx;
  logic [DEPTH_W-1:0] depth_n;
  logic               underflow_n;
  logic [7:0]         out_n;
  logic               out_valid_n;
  logic               at_last, accept;

  function automatic logic [7:0] char_at(input word_t w, input logic [2:0] i);
    logic [7:0] c;
    c = 8'h20;
    case (w)
      W_BEGIN: case (i)
        3'd0: c = 8'h62;
        3'd1: c = 8'h65;
        3'd2: c = 8'h67;
        3'd3: c = 8'h69;
        3'd4: c = 8'h6E;
        default: c = 8'h20;
      endcase
      W_END: case (i)
        3'd0: c = 8'h65;
        3'd1: c = 8'h6E;
        3'd2: c = 8'h64;
        default: c = 8'h20;
      endcase
      default: case (i)
        3'd0: c = 8'h6E;
        3'd1: c = 8'h6F;
        3'd2: c = 8'h70;
        default: c = 8'h20;
      endcase
    endcase
    if (UPPER_CASE != 0 && c != 8'h20) c = c - 8'h20;
    return c;
  endfunction

  // idx names the character being loaded into out this cycle, so ready on the
  // last index lets the next word's first char follow the space with no gap.
  always_comb begin
    last_idx = (word == W_BEGIN) ? 3'd5 : 3'd3;
    at_last  = 1'b0;
    if (state == EMIT)            at_last = (idx == last_idx);
    else if (state == FLUSH_EMIT) at_last = (idx == 3'd3) && (depth == '0);
    cmd_ready = !reset && ((state == IDLE) || at_last);
    accept    = cmd_valid && cmd_ready;
    balanced  = (state == IDLE) && !out_valid && (depth == '0) && !underflow;
  end

  always_comb begin
    state_n     = state;
    word_n      = word;
    idx_n       = idx;
    depth_n     = depth;
    underflow_n = underflow;
    out_n       = '0;
    out_valid_n = 1'b0;

    if (state != IDLE) begin
      out_n       = char_at(word, idx);
      out_valid_n = 1'b1;
      if (state == EMIT) begin
        if (idx == last_idx) state_n = IDLE;
        else                 idx_n   = idx + 3'd1;
      end else begin
        if (idx == 3'd0) depth_n = depth - DEPTH_W'(1);
        // depth already counts this round's "e", so zero here means final round
        if (idx == 3'd3) begin
          if (depth == '0) state_n = IDLE;
          else             idx_n   = 3'd0;
        end else begin
          idx_n = idx + 3'd1;
        end
      end
    end

    if (accept) begin
      case (op_t'(cmd_op))
        OP_BEGIN: begin
          state_n = EMIT;
          word_n  = W_BEGIN;
          idx_n   = 3'd0;
          if (depth != '1) depth_n = depth + DEPTH_W'(1);
        end
        OP_END: begin
          if (depth != '0) begin
            depth_n = depth - DEPTH_W'(1);
            state_n = EMIT;
            word_n  = W_END;
            idx_n   = 3'd0;
          end else begin
`ifdef BLOCK_EMIT_STRICT_EN
            underflow_n = 1'b0;
`else
            state_n     = EMIT;
            word_n      = W_END;
            idx_n       = 3'd0;
            underflow_n = 1'b1;
`endif
          end
        end
        OP_NOP: begin
          state_n = EMIT;
          word_n  = W_NOP;
          idx_n   = 3'd0;
        end
        OP_FLUSH: begin
          if (depth != '0) begin
            state_n = FLUSH_EMIT;
            word_n  = W_END;
            idx_n   = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word      <= W_NOP;
      idx       <= '0;
      depth     <= '0;
      underflow <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      word      <= word_n;
      idx       <= idx_n;
      depth     <= depth_n;
      underflow <= underflow_n;
      out       <= out_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_block_stream_emitter.sv
// Directed bench for block_stream_emitter: three instances (default, uppercase, 2-bit depth)
// sharing command inputs, with a target select choosing which one is driven and observed.
module tb_block_stream_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  target;

  logic        rdy_m, ov_m, uf_m, bal_m;
  logic [7:0]  out_m;
  logic [15:0] depth_m;
  logic        rdy_u, ov_u, uf_u, bal_u;
  logic [7:0]  out_u;
  logic [15:0] depth_u;
  logic        rdy_s, ov_s, uf_s, bal_s;
  logic [7:0]  out_s;
  logic [1:0]  depth_s;

  logic        sel_ready, sel_valid, sel_under, sel_bal;
  logic [7:0]  sel_out;
  logic [15:0] sel_depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_stream_emitter #(.DEPTH_W(16), .UPPER_CASE(0)) dut_main (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid && target == 2'd0), .cmd_op(cmd_op),
    .cmd_ready(rdy_m), .out(out_m), .out_valid(ov_m), .depth(depth_m),
    .underflow(uf_m), .balanced(bal_m));

  block_stream_emitter #(.DEPTH_W(16), .UPPER_CASE(1)) dut_uc (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid && target == 2'd1), .cmd_op(cmd_op),
    .cmd_ready(rdy_u), .out(out_u), .out_valid(ov_u), .depth(depth_u),
    .underflow(uf_u), .balanced(bal_u));

  block_stream_emitter #(.DEPTH_W(2), .UPPER_CASE(0)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid && target == 2'd2), .cmd_op(cmd_op),
    .cmd_ready(rdy_s), .out(out_s), .out_valid(ov_s), .depth(depth_s),
    .underflow(uf_s), .balanced(bal_s));

  always_comb begin
    case (target)
      2'd1: begin
        sel_ready = rdy_u; sel_out = out_u; sel_valid = ov_u;
        sel_depth = depth_u; sel_under = uf_u; sel_bal = bal_u;
      end
      2'd2: begin
        sel_ready = rdy_s; sel_out = out_s; sel_valid = ov_s;
        sel_depth = {14'd0, depth_s}; sel_under = uf_s; sel_bal = bal_s;
      end
      default: begin
        sel_ready = rdy_m; sel_out = out_m; sel_valid = ov_m;
        sel_depth = depth_m; sel_under = uf_m; sel_bal = bal_m;
      end
    endcase
  end

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic        ev;
    logic [7:0]  eo;
    logic [15:0] ed;
    logic        er;
    logic        eb;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1 check("ready during reset", {31'd0, sel_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset out_valid", {31'd0, sel_valid}, 32'd0);
    check("reset out", {24'd0, sel_out}, 32'd0);
    check("reset depth", {16'd0, sel_depth}, 32'd0);
    check("reset underflow", {31'd0, sel_under}, 32'd0);
    check("reset balanced", {31'd0, sel_bal}, 32'd1);
  endtask

  // Holds cmd_valid until n commands are accepted, then waits for idle while
  // comparing every emitted character against a repeating pattern.
  task automatic stream(input logic [1:0] op, input int n, input string pat,
                        input int exp_count, input string name);
    int acc = 0, cnt = 0, cyc = 0, since = 0, bad = 0;
    logic done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cmd_op = op;
      cmd_valid = (acc < n);
      #1;
      cyc++;
      if (sel_valid) begin
        if (pat.len() == 0 || sel_out !== pat[cnt % pat.len()]) bad++;
        cnt++;
      end
      if (cmd_valid && sel_ready) begin
        acc++;
        since = 0;
      end else begin
        since++;
      end
      if (acc == n && since > 0 && sel_ready && !sel_valid) done = 1'b1;
    end
    cmd_valid = 1'b0;
    check({name, " completes"}, {31'd0, done}, 32'd1);
    check({name, " char count"}, cnt, exp_count);
    check({name, " char pattern"}, bad, 32'd0);
  endtask

  initial begin
    string endpat;
    endpat    = "end ";
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    target    = 2'd0;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'h00, 16'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 8'h62, 16'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 8'h65, 16'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 8'h67, 16'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 8'h69, 16'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 1'b1, 8'h6E, 16'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 8'h20, 16'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 8'h65, 16'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 8'h6E, 16'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 8'h64, 16'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 8'h20, 16'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b1};

    // BEGIN then END back-to-back
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      #1;
      check($sformatf("row%0d out_valid", i), {31'd0, sel_valid}, {31'd0, tbl[i].ev});
      check($sformatf("row%0d out", i), {24'd0, sel_out}, {24'd0, tbl[i].eo});
      check($sformatf("row%0d depth", i), {16'd0, sel_depth}, {16'd0, tbl[i].ed});
      check($sformatf("row%0d ready", i), {31'd0, sel_ready}, {31'd0, tbl[i].er});
      check($sformatf("row%0d balanced", i), {31'd0, sel_bal}, {31'd0, tbl[i].eb});
    end
    cmd_valid = 1'b0;

    // BEGIN x3 then FLUSH from idle
    do_reset();
    stream(2'd0, 3, "begin ", 18, "begin x3");
    check("depth after begin x3", {16'd0, sel_depth}, 32'd3);
    @(negedge clk);
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    #1 check("flush accept ready", {31'd0, sel_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("flush lead out_valid", {31'd0, sel_valid}, 32'd0);
    check("flush lead depth", {16'd0, sel_depth}, 32'd3);
    check("flush lead ready", {31'd0, sel_ready}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("flush%0d out", k), {24'd0, sel_out}, {24'd0, endpat[k % 4]});
      check($sformatf("flush%0d depth", k), {16'd0, sel_depth}, 2 - k / 4);
      check($sformatf("flush%0d ready", k), {31'd0, sel_ready}, (k >= 10) ? 32'd1 : 32'd0);
      check($sformatf("flush%0d balanced", k), {31'd0, sel_bal}, 32'd0);
    end
    @(negedge clk);
    #1;
    check("post flush out_valid", {31'd0, sel_valid}, 32'd0);
    check("post flush balanced", {31'd0, sel_bal}, 32'd1);

    // END at depth 0
    do_reset();
`ifdef BLOCK_EMIT_STRICT_EN
    stream(2'd1, 1, "", 0, "end at 0 strict");
    @(negedge clk);
    #1;
    check("strict underflow", {31'd0, sel_under}, 32'd0);
    check("strict ready", {31'd0, sel_ready}, 32'd1);
    check("strict balanced", {31'd0, sel_bal}, 32'd1);
`else
    stream(2'd1, 1, "end ", 4, "end at 0");
    repeat (3) @(negedge clk);
    #1;
    check("underflow sticky", {31'd0, sel_under}, 32'd1);
    check("underflow depth", {16'd0, sel_depth}, 32'd0);
    check("underflow unbalanced", {31'd0, sel_bal}, 32'd0);
`endif

    // reset on the third character of "begin "
    do_reset();
    @(negedge clk);
    cmd_op = 2'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 check("mid-word third char", {24'd0, sel_out}, 32'h67);
    reset = 1'b1;
    #1 check("mid-word ready in reset", {31'd0, sel_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort out_valid", {31'd0, sel_valid}, 32'd0);
    check("abort out", {24'd0, sel_out}, 32'd0);
    check("abort depth", {16'd0, sel_depth}, 32'd0);
    stream(2'd2, 1, "nop ", 4, "nop after abort");

    // uppercase instance
    target = 2'd1;
    do_reset();
    stream(2'd2, 1, "NOP ", 4, "uppercase nop");
    check("uppercase depth", {16'd0, sel_depth}, 32'd0);

    // 2-bit depth saturation
    target = 2'd2;
    do_reset();
    stream(2'd0, 4, "begin ", 24, "saturating begin x4");
    check("saturated depth", {16'd0, sel_depth}, 32'd3);
    stream(2'd3, 1, "end ", 12, "saturated flush");
    check("sat flush depth", {16'd0, sel_depth}, 32'd0);
    check("sat flush balanced", {31'd0, sel_bal}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
